// File: rtl/traffic_phase_fsm.sv
// Intersection phase sequencer: holds the signal phase, feeds reload values to the countdown timer, decodes lamps.
// Optional all-red pedestrian walk phase enabled by defining PED_CROSS_EN.
package traffic_phase_pkg;
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        WALK      = 3'd6
    } phase_t;
endpackage

module traffic_phase_fsm
    import traffic_phase_pkg::*;
#(
    parameter logic [4:0] GREEN_DUR   = 5'd20,
    parameter logic [4:0] YELLOW_DUR  = 5'd3,
    parameter logic [4:0] RED_CLR_DUR = 5'd1,
    parameter logic [4:0] WALK_DUR    = 5'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] timer_n,
    input  logic       ped_req,
    output logic [4:0] duration,
    output logic [2:0] phase,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic       phase_done
);

    phase_t state_q, state_d, nxt_seq;
    logic   illegal, advance, pend_q, ped_ack_q, phase_done_q;

    function automatic logic [4:0] dur_of(input phase_t p);
        case (p)
            NS_GREEN, EW_GREEN:   dur_of = GREEN_DUR;
            NS_YELLOW, EW_YELLOW: dur_of = YELLOW_DUR;
`ifdef PED_CROSS_EN
            WALK:                 dur_of = WALK_DUR;
`endif
            default:              dur_of = RED_CLR_DUR;
        endcase
    endfunction

    always_comb begin
        illegal = 1'b0;
        nxt_seq = NS_GREEN;
        case (state_q)
            NS_GREEN:  nxt_seq = NS_YELLOW;
            NS_YELLOW: nxt_seq = ALL_RED_A;
            ALL_RED_A: nxt_seq = EW_GREEN;
            EW_GREEN:  nxt_seq = EW_YELLOW;
            EW_YELLOW: nxt_seq = ALL_RED_B;
            ALL_RED_B: nxt_seq = pend_q ? WALK : NS_GREEN;
`ifdef PED_CROSS_EN
            WALK:      nxt_seq = NS_GREEN;
`endif
            default: begin
                illegal = 1'b1;
                nxt_seq = ALL_RED_B;
            end
        endcase
        // An illegal code escapes on the next edge regardless of the timer.
        advance  = illegal || (timer_n == 5'd0);
        state_d  = advance ? nxt_seq : state_q;
        duration = reset ? GREEN_DUR : (advance ? dur_of(nxt_seq) : dur_of(state_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= NS_GREEN;
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_done_q <= advance;
        end
    end

`ifdef PED_CROSS_EN
    // A request on the serving edge re-arms the flag for the following round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q    <= 1'b0;
            ped_ack_q <= 1'b0;
        end else begin
            pend_q    <= ped_req | (pend_q & ~(advance && state_q == ALL_RED_B));
            ped_ack_q <= advance && state_q == ALL_RED_B && pend_q;
        end
    end
    assign walk = (state_q == WALK);
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign pend_q     = 1'b0;
    assign ped_ack_q  = 1'b0;
    assign walk       = 1'b0;
`endif

    always_comb begin
        ns_light = 3'b100;
        ew_light = 3'b100;
        case (state_q)
            NS_GREEN:  ns_light = 3'b001;
            NS_YELLOW: ns_light = 3'b010;
            EW_GREEN:  ew_light = 3'b001;
            EW_YELLOW: ew_light = 3'b010;
            default: ;
        endcase
    end

    assign phase      = state_q;
    assign ped_ack    = ped_ack_q;
    assign phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed bench for traffic_phase_fsm with a countdown timer model; walk checks active when PED_CROSS_EN is defined.
module tb_traffic_phase_fsm;
    import traffic_phase_pkg::*;

`ifdef PED_CROSS_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ped_req = 1'b0;
    logic       force0 = 1'b0;
    logic [4:0] tmr, timer_n, duration;
    logic [2:0] phase, ns_light, ew_light;
    logic       walk, ped_ack, phase_done;
    int         cyc = 0;
    int         n_asrt = 0;
    int         n_fail = 0;
    int         t0;

    traffic_phase_fsm dut (
        .clk(clk), .reset(reset), .timer_n(timer_n), .ped_req(ped_req),
        .duration(duration), .phase(phase), .ns_light(ns_light), .ew_light(ew_light),
        .walk(walk), .ped_ack(ped_ack), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    // Countdown timer: reloads from duration when it reaches zero.
    assign timer_n = force0 ? 5'd0 : tmr;
    always @(posedge clk or posedge reset) begin
        if (reset) tmr <= 5'd20;
        else       tmr <= (timer_n == 5'd0) ? duration : timer_n - 5'd1;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at the first sample of a phase; returns at the first sample of the next one.
    task automatic check_phase(input logic [2:0] p, input logic [2:0] ns, input logic [2:0] ew,
                               input logic w, input logic [4:0] dur, input int len,
                               input int done_n, input int ack_n, input int pulse_at);
        int n = 0, nd = 0, na = 0;
        chk($sformatf("phase%0d_code", p), phase, p);
        chk($sformatf("phase%0d_ns", p), ns_light, ns);
        chk($sformatf("phase%0d_ew", p), ew_light, ew);
        chk($sformatf("phase%0d_walk", p), walk, w);
        chk($sformatf("phase%0d_dur", p), duration, dur);
        while (phase === p && n < 100) begin
            ped_req = (n == pulse_at);
            nd += int'(phase_done);
            na += int'(ped_ack);
            n++;
            @(negedge clk);
        end
        ped_req = 1'b0;
        chk($sformatf("phase%0d_len", p), n, len);
        chk($sformatf("phase%0d_done", p), nd, done_n);
        chk($sformatf("phase%0d_ack", p), na, ack_n);
    endtask

    task automatic run_round(input int ng_pulse, input int rb_pulse, input bit exp_walk, input int ng_done);
        check_phase(3'd0, 3'b001, 3'b100, 1'b0, 5'd20, 21, ng_done, 0, ng_pulse);
        check_phase(3'd1, 3'b010, 3'b100, 1'b0, 5'd3, 4, 1, 0, -1);
        check_phase(3'd2, 3'b100, 3'b100, 1'b0, 5'd1, 2, 1, 0, -1);
        check_phase(3'd3, 3'b100, 3'b001, 1'b0, 5'd20, 21, 1, 0, -1);
        check_phase(3'd4, 3'b100, 3'b010, 1'b0, 5'd3, 4, 1, 0, -1);
        check_phase(3'd5, 3'b100, 3'b100, 1'b0, 5'd1, 2, 1, 0, rb_pulse);
        if (exp_walk) check_phase(3'd6, 3'b100, 3'b100, 1'b1, 5'd10, 11, 1, 1, -1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_phase", phase, 3'd0);
        chk("rst_ns", ns_light, 3'b001);
        chk("rst_ew", ew_light, 3'b100);
        chk("rst_walk", walk, 1'b0);
        chk("rst_ack", ped_ack, 1'b0);
        chk("rst_done", phase_done, 1'b0);
        chk("rst_dur", duration, 5'd20);

        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        t0 = cyc;
        run_round(-1, -1, 1'b0, 0);
        chk("round_cycles", cyc - t0, 54);

        check_phase(3'd0, 3'b001, 3'b100, 1'b0, 5'd20, 21, 1, 0, -1);
        check_phase(3'd1, 3'b010, 3'b100, 1'b0, 5'd3, 4, 1, 0, -1);
        check_phase(3'd2, 3'b100, 3'b100, 1'b0, 5'd1, 2, 1, 0, -1);
        chk("ewg_phase", phase, 3'd3);
        chk("ewg_dur", duration, 5'd20);
        chk("ewg_done", phase_done, 1'b1);
        ped_req = 1'b1;
        @(negedge clk); ped_req = 1'b0;
        @(negedge clk); force0 = 1'b1;
        #1;
        chk("zero_dur_lookahead", duration, 5'd3);
        chk("zero_phase_holds", phase, 3'd3);
        chk("zero_ew_holds", ew_light, 3'b001);
        @(negedge clk); force0 = 1'b0;
        #1;
        chk("ewy_phase", phase, 3'd4);
        chk("ewy_ew", ew_light, 3'b010);
        chk("ewy_ns", ns_light, 3'b100);
        chk("ewy_dur", duration, 5'd3);
        chk("ewy_done", phase_done, 1'b1);

        @(negedge clk); #2 reset = 1'b1;
        #1;
        chk("midrst_phase", phase, 3'd0);
        chk("midrst_ns", ns_light, 3'b001);
        chk("midrst_ew", ew_light, 3'b100);
        chk("midrst_dur", duration, 5'd20);
        chk("midrst_done", phase_done, 1'b0);

        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        force dut.state_q = phase_t'(3'd7);
        #1;
        chk("illegal_ns", ns_light, 3'b100);
        chk("illegal_ew", ew_light, 3'b100);
        chk("illegal_walk", walk, 1'b0);
        chk("illegal_dur", duration, 5'd1);
        release dut.state_q;
        @(negedge clk);
        check_phase(3'd5, 3'b100, 3'b100, 1'b0, 5'd1, 19, 1, 0, -1);

        // Request pulse in NS_GREEN, and again on the ALL_RED_B expiry edge.
        run_round(0, 1, PED, 1);
        run_round(-1, -1, PED, 1);
        run_round(-1, -1, 1'b0, 1);
        chk("final_phase", phase, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/traffic_phase_fsm.md
# traffic_phase_fsm

Phase sequencer for the two-road intersection, directly upstream of the countdown timer. It holds the current signal phase, gives the timer the reload duration for each phase, and advances when the timer reports zero. It also drives the north-south and east-west lamp outputs. As an option it serves a latched pedestrian request with an all-red walk phase.

## Interface
- `GREEN_DUR`, 20: green phase reload value, 1..31.
- `YELLOW_DUR`, 3: yellow phase reload value, 1..31.
- `RED_CLR_DUR`, 1: all-red clearance reload value, 1..31.
- `WALK_DUR`, 10: walk phase reload value, 1..31. Used only with `PED_CROSS_EN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `timer_n`  in  5  current countdown value from the timer.
- `ped_req`  in  1  pedestrian push-button; a level or a pulse of at least 1 cycle.
- `duration`  out  5  reload value presented to the timer.
- `phase`  out  3  current phase code.
- `ns_light`  out  3  north-south lamps, {red, yellow, green}.
- `ew_light`  out  3  east-west lamps, {red, yellow, green}.
- `walk`  out  1  pedestrian walk lamp.
- `ped_ack`  out  1  one-cycle pulse when the walk phase is entered.
- `phase_done`  out  1  registered one-cycle pulse in the first cycle of each new phase.

## Operation
- Phase codes:
  - NS_GREEN = 0
  - NS_YELLOW = 1
  - ALL_RED_A = 2
  - EW_GREEN = 3
  - EW_YELLOW = 4
  - ALL_RED_B = 5
  - WALK = 6
- Sequence: 0 → 1 → 2 → 3 → 4 → 5 → 0. With `PED_CROSS_EN` and a pending request, 5 → 6 → 0.
- Advance condition: `timer_n == 0` at a rising edge. Otherwise the phase holds.
- `duration` is combinational lookahead:
  - when `timer_n == 0`, it shows the duration of the *next* phase;
  - otherwise it shows the duration of the current phase.
  - This way the timer's reload on the same edge picks up the correct value.
- While `reset` is high, `duration` = `GREEN_DUR`, so the timer's async reload matches NS_GREEN.
- Lamp decode from the `phase` register:
  - NS_GREEN: `ns_light` = 001, `ew_light` = 100.
  - NS_YELLOW: `ns_light` = 010, `ew_light` = 100.
  - EW_GREEN: `ns_light` = 100, `ew_light` = 001.
  - EW_YELLOW: `ns_light` = 100, `ew_light` = 010.
  - ALL_RED_A, ALL_RED_B and WALK: both = 100.
  - `walk` = 1 only in WALK.
- Illegal phase code (7, or 6 without the macro): both roads red; next edge goes to ALL_RED_B with `duration` = `RED_CLR_DUR`.
- Width rule: all durations are 5-bit unsigned. A phase with reload value D lasts D+1 clock cycles, because the timer counts D..0.

## Timing
- Reset values:
  - `phase` = 0, `ns_light` = 001, `ew_light` = 100.
  - `walk` = 0, `ped_ack` = 0, `phase_done` = 0.
  - `duration` = `GREEN_DUR`.
  - Pedestrian pending flag = 0.
- Transition latency: lamps change 1 cycle after the edge where `timer_n == 0` was sampled. No combinational path from `timer_n` to lamps.
- `phase_done` and `ped_ack` are high for exactly the first cycle of the new phase.
- Reset asserted mid-phase: immediate return to NS_GREEN with reset values, and the pending request is discarded. Operation resumes on the first edge after deassertion.
- `timer_n` stuck non-zero: the phase holds indefinitely. No internal watchdog.

## Configuration
- `PED_CROSS_EN` defined:
  - `ped_req` sets a sticky pending flag on any edge where it is high.
  - At the ALL_RED_B expiry edge, a set flag routes to WALK, clears the flag and pulses `ped_ack`.
  - A `ped_req` high on that same edge re-sets the flag; set wins over clear. It is served on the next cycle round.
- `PED_CROSS_EN` undefined:
  - WALK state and the pending flag are absent.
  - `ped_req` is ignored; `walk` and `ped_ack` are tied 0.
  - Sequence is fixed 0..5.

## Test plan
- Reset with defaults, timer model counting down each clk → NS_GREEN lasts 21 cycles, NS_YELLOW 4, ALL_RED_A 2; full round is 54 cycles; `phase_done` pulses 6 times per round.
- Hold `timer_n` = 0 one cycle during EW_GREEN → `duration` = 3 in that cycle; next cycle `phase` = 4 and `ew_light` = 010.
- `PED_CROSS_EN`, 1-cycle `ped_req` during NS_GREEN → after ALL_RED_B, `phase` = 6, `walk` = 1 for 11 cycles, single `ped_ack`, then NS_GREEN.
- `PED_CROSS_EN`, `ped_req` high on the ALL_RED_B→WALK edge → WALK served now; pending stays set; WALK repeats next round.
- Assert `reset` mid-EW_YELLOW → `phase` = 0, `ns_light` = 001 and `duration` = 20 asynchronously; pending cleared.
- Force `phase` to 7 → both roads red; next edge `phase` = 5 and `duration` = 1.
